psum_sc_drain_ctrl: RTL and testbench
=====================================

Name: psum_sc_drain_ctrl

Overview:
- Sequences readout of the partial-sum scratchpad once a PE pass finishes.
- Streams entries 0..num_entries-1 to the output buffer over a valid/ready handshake.
- Optionally zeroes each entry after it is read.
- Owns the scratchpad ports while draining and stalls the PE pipeline until drain completes.

Parameters:
- PSUM_SC_ADDR_LEN, 8, scratchpad address width; depth = 2^PSUM_SC_ADDR_LEN.
- PSUM_WIDTH, 16, scratchpad / output data width.
- CLEAR_ON_DRAIN, 1, when 1, write zero to each entry one cycle after its read.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a drain (driven from psum_sc_done).
- num_entries  in  PSUM_SC_ADDR_LEN+1  entries to drain; sampled on accepted start.
- sc_ren  out  1  scratchpad read enable.
- sc_raddr  out  PSUM_SC_ADDR_LEN  scratchpad read address.
- sc_rdata  in  PSUM_WIDTH  read data; valid the cycle after sc_ren.
- sc_wen  out  1  scratchpad clear-write enable.
- sc_waddr  out  PSUM_SC_ADDR_LEN  clear-write address.
- sc_wdata  out  PSUM_WIDTH  always zero.
- out_valid  out  1  output word valid.
- out_ready  in  1  output buffer accepts the word.
- out_data  out  PSUM_WIDTH  output psum.
- out_last  out  1  qualifies the final word of the drain.
- busy  out  1  drain in progress.
- stall_pipeline  out  1  freezes the PE pipeline; equals busy.
- done  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset: all outputs 0; state IDLE; counters, skid FIFO and in-flight flag cleared. Reset mid-drain aborts immediately. No partial clear is undone.
- FSM states: IDLE, DRAIN, FIN.
  - IDLE: start with num_entries>0 goes to DRAIN. start with num_entries==0 goes to FIN; no reads are issued.
  - DRAIN: when the issued count equals num and the last word has been popped, go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- start is ignored unless in IDLE. num_entries is latched as num on the accepted start.
- busy = stall_pipeline = (state != IDLE).
- Read issue (DRAIN only), per cycle:
  - sc_ren=1 when rd_cnt < num AND (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
  - sc_raddr = rd_cnt[PSUM_SC_ADDR_LEN-1:0]; rd_cnt increments on each issue.
- Read return: the cycle after sc_ren, sc_rdata is pushed into a 2-entry FIFO with tag last = (addr == num-1).
  - If CLEAR_ON_DRAIN: same cycle sc_wen=1, sc_waddr = that address, sc_wdata=0.
  - A write never targets the address being read that cycle.
- Output: out_valid = FIFO non-empty; out_data and out_last come from the FIFO head.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - The FIFO never overflows. Push and pop in the same cycle is legal.
- Timing with out_ready=1: start in cycle 0, then:
  - sc_ren for addr 0 in cycle 1.
  - sc_wen for addr 0 in cycle 2.
  - out_valid with word 0 in cycle 3.
  - One word per cycle thereafter: word N-1 in cycle N+2, done in cycle N+3.
- num_entries = 2^PSUM_SC_ADDR_LEN is legal. rd_cnt is PSUM_SC_ADDR_LEN+1 bits, so there is no premature wrap; sc_raddr wraps naturally after the last read.
- out_ready toggling in any pattern must not drop, duplicate or reorder words.

Decomposition:
- Shared package psum_pkg: FSM state encoding (IDLE/DRAIN/FIN) and default PSUM_WIDTH constant.
- Sub-module psum_drain_skid: 2-entry FIFO of {last, data} with push, pop, count, empty and full.
- The FSM and counters stay in the top module.

Test Plan:
- N=4, scratchpad holds 10,20,30,40, out_ready=1 -> out_data 10,20,30,40 in cycles 3..6; out_last only with 40; done in cycle 7; entries 0..3 read back 0.
- N=4, out_ready high only on odd cycles -> same ordered 4 words, no duplicates; FIFO count never exceeds 2; done one cycle after the last pop.
- N=0 start -> done the next cycle; no sc_ren, sc_wen or out_valid at any time.
- N=256 (PSUM_SC_ADDR_LEN=8), random ready -> 256 words in address order, out_last only on addr 255, exactly 256 clears.
- rst asserted in cycle 5 of an N=8 drain -> all outputs 0 immediately; a new start N=2 afterwards drains cleanly from addr 0.
- second start pulse during busy with num_entries=3 -> ignored; the original N=6 drain completes with exactly 6 words and one done pulse.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared types and defaults for the partial-sum scratchpad drain path.
package psum_pkg;

  localparam int unsigned PsumWidthDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFin
  } drain_state_e;

endpackage

// File: rtl/psum_drain_skid.sv
// Two-entry FIFO of {last, data} between scratchpad read return and the output handshake.
module psum_drain_skid #(
  parameter int unsigned Width = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/psum_sc_drain_ctrl.sv
// Streams the partial-sum scratchpad to the output buffer after a PE pass, optionally
// zeroing each entry behind the read, and holds the PE pipeline until the drain ends.
module psum_sc_drain_ctrl
  import psum_pkg::*;
#(
  parameter int unsigned PSUM_SC_ADDR_LEN = 8,
  parameter int unsigned PSUM_WIDTH       = PsumWidthDefault,
  parameter bit          CLEAR_ON_DRAIN   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [PSUM_SC_ADDR_LEN:0]   num_entries_i,
  output logic                        sc_ren_o,
  output logic [PSUM_SC_ADDR_LEN-1:0] sc_raddr_o,
  input  logic [PSUM_WIDTH-1:0]       sc_rdata_i,
  output logic                        sc_wen_o,
  output logic [PSUM_SC_ADDR_LEN-1:0] sc_waddr_o,
  output logic [PSUM_WIDTH-1:0]       sc_wdata_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [PSUM_WIDTH-1:0]       out_data_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic                        stall_pipeline_o,
  output logic                        done_o
);

  localparam int unsigned AW = PSUM_SC_ADDR_LEN;
  localparam logic [AW:0] CntOne = 1;

  drain_state_e state_q, state_d;

  logic [AW:0]         num_q, num_d;
  logic [AW:0]         rd_cnt_q, rd_cnt_d;
  logic                inflight_q, inflight_d;
  logic                infl_last_q, infl_last_d;
  logic [AW-1:0]       infl_addr_q, infl_addr_d;
  logic [PSUM_WIDTH:0] fifo_head;
  logic [1:0]          fifo_count;
  logic                fifo_empty, fifo_full;
  logic                pop;
  logic [2:0]          occupancy;

  // The read returning this cycle lands in the FIFO, tagged with whether it is the final word.
  psum_drain_skid #(
    .Width(PSUM_WIDTH + 1)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i({infl_last_q, sc_rdata_i}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign out_valid_o      = ~fifo_empty;
  assign out_data_o       = fifo_empty ? '0 : fifo_head[PSUM_WIDTH-1:0];
  assign out_last_o       = ~fifo_empty & fifo_head[PSUM_WIDTH];
  assign pop              = out_valid_o & out_ready_i;

  assign sc_raddr_o       = rd_cnt_q[AW-1:0];
  assign sc_wen_o         = CLEAR_ON_DRAIN & inflight_q;
  assign sc_waddr_o       = infl_addr_q;
  assign sc_wdata_o       = '0;

  assign busy_o           = (state_q != StIdle);
  assign stall_pipeline_o = busy_o;

  // Words held or returning after this cycle's pop; capped at the FIFO depth.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    rd_cnt_d    = rd_cnt_q;
    inflight_d  = 1'b0;
    infl_last_d = infl_last_q;
    infl_addr_d = infl_addr_q;
    sc_ren_o    = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          num_d    = num_entries_i;
          rd_cnt_d = '0;
          state_d  = (num_entries_i == '0) ? StFin : StDrain;
        end
      end
      StDrain: begin
        if ((rd_cnt_q < num_q) && (occupancy < 3'd2)) begin
          sc_ren_o    = 1'b1;
          rd_cnt_d    = rd_cnt_q + CntOne;
          inflight_d  = 1'b1;
          infl_addr_d = rd_cnt_q[AW-1:0];
          infl_last_d = ((rd_cnt_q + CntOne) == num_q);
        end
        if ((rd_cnt_q == num_q) && pop && fifo_head[PSUM_WIDTH]) begin
          state_d = StFin;
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      num_q       <= '0;
      rd_cnt_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      infl_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      rd_cnt_q    <= rd_cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      infl_addr_q <= infl_addr_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_full && inflight_q && !pop));

endmodule

// File: tb/tb_psum_sc_drain_ctrl.sv
// Bench for psum_sc_drain_ctrl: scratchpad memory model, random ready, queue-based reference.
module tb_psum_sc_drain_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW:0]   num_entries_i;
  logic          sc_ren_o;
  logic [AW-1:0] sc_raddr_o;
  logic [DW-1:0] sc_rdata_i;
  logic          sc_wen_o;
  logic [AW-1:0] sc_waddr_o;
  logic [DW-1:0] sc_wdata_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          stall_pipeline_o;
  logic          done_o;

  always #5 clk = ~clk;

  psum_sc_drain_ctrl #(
    .PSUM_SC_ADDR_LEN(AW),
    .PSUM_WIDTH      (DW),
    .CLEAR_ON_DRAIN  (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .num_entries_i   (num_entries_i),
    .sc_ren_o        (sc_ren_o),
    .sc_raddr_o      (sc_raddr_o),
    .sc_rdata_i      (sc_rdata_i),
    .sc_wen_o        (sc_wen_o),
    .sc_waddr_o      (sc_waddr_o),
    .sc_wdata_o      (sc_wdata_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_data_o      (out_data_o),
    .out_last_o      (out_last_o),
    .busy_o          (busy_o),
    .stall_pipeline_o(stall_pipeline_o),
    .done_o          (done_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scratchpad model: one-cycle read latency, bulk load on request.
  logic [DW-1:0] mem       [Depth];
  logic [DW-1:0] init_vals [Depth];
  logic          load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < Depth; i++) mem[i] <= init_vals[i];
    end else if (sc_wen_o) begin
      mem[sc_waddr_o] <= sc_wdata_o;
    end
    if (sc_ren_o) sc_rdata_i <= mem[sc_raddr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: always ready, 1: ready on odd cycles, 2: random.
  int rdy_mode = 0;
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = cyc[0];
        default: out_ready_i = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  bit          mon_en = 1'b0;
  int          start_cyc;
  int          first_ren, first_wen, first_out, done_cyc, last_pop_cyc;
  int          done_cnt, busy_cnt, valid_cnt;
  int          hold_err, stall_err, occ_err, wdata_err;
  int          ren_q[$], wen_q[$], got_d[$], got_l[$];
  bit          hold_pend;
  logic [DW-1:0] hold_d;
  logic        hold_l;

  task automatic clear_log();
    first_ren = -1; first_wen = -1; first_out = -1; done_cyc = -1; last_pop_cyc = -1;
    done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
    hold_err = 0; stall_err = 0; occ_err = 0; wdata_err = 0;
    hold_pend = 1'b0;
    ren_q.delete(); wen_q.delete(); got_d.delete(); got_l.delete();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (hold_pend && !(out_valid_o && out_data_o == hold_d && out_last_o == hold_l))
          hold_err++;
        hold_pend = out_valid_o && !out_ready_i;
        hold_d    = out_data_o;
        hold_l    = out_last_o;
        if (sc_ren_o) begin
          ren_q.push_back(int'(sc_raddr_o));
          if (first_ren < 0) first_ren = cyc - start_cyc;
        end
        if (sc_wen_o) begin
          wen_q.push_back(int'(sc_waddr_o));
          if (sc_wdata_o != '0) wdata_err++;
          if (first_wen < 0) first_wen = cyc - start_cyc;
        end
        if (out_valid_o) begin
          valid_cnt++;
          if (first_out < 0) first_out = cyc - start_cyc;
        end
        if (out_valid_o && out_ready_i) begin
          got_d.push_back(int'(out_data_o));
          got_l.push_back(int'(out_last_o));
          last_pop_cyc = cyc;
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (busy_o) busy_cnt++;
        if (stall_pipeline_o != busy_o) stall_err++;
        if (ren_q.size() - got_d.size() > 2) occ_err++;
      end
    end
  end

  task automatic load_mem(input bit directed);
    for (int i = 0; i < Depth; i++) init_vals[i] = 16'($urandom_range(1, 65535));
    if (directed) begin
      init_vals[0] = 16'd10; init_vals[1] = 16'd20;
      init_vals[2] = 16'd30; init_vals[3] = 16'd40;
    end
    @(posedge clk);
    #1;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic run_drain(input int n, input int mode, input bit intr, input bit directed);
    bit timed_out;
    int bad;
    int tmp;
    load_mem(directed);
    rdy_mode = mode;
    clear_log();
    @(posedge clk);
    #1;
    start_i       = 1'b1;
    num_entries_i = n[AW:0];
    start_cyc     = cyc;
    mon_en        = 1'b1;
    timed_out     = 1'b1;
    for (int k = 1; k <= n * 8 + 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        start_i       = 1'b0;
        tmp           = $urandom_range(0, Depth);
        num_entries_i = tmp[AW:0];
      end
      if (intr && k == 3) begin
        start_i       = 1'b1;
        num_entries_i = 9'd3;
      end
      if (intr && k == 4) start_i = 1'b0;
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_eq("timeout", timed_out, 0);
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;

    check_eq("words", got_d.size(), n);
    for (int i = 0; i < got_d.size() && i < n; i++)
      check_eq($sformatf("data[%0d]", i), got_d[i], init_vals[i]);
    bad = 0;
    for (int i = 0; i < got_l.size(); i++) if (got_l[i] != ((i == n - 1) ? 1 : 0)) bad++;
    check_eq("last_flags", bad, 0);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("reads", ren_q.size(), n);
    bad = 0;
    for (int i = 0; i < ren_q.size(); i++) if (ren_q[i] != i) bad++;
    check_eq("read_order", bad, 0);
    check_eq("clears", wen_q.size(), n);
    bad = 0;
    for (int i = 0; i < wen_q.size(); i++) if (wen_q[i] != i) bad++;
    check_eq("clear_order", bad, 0);
    check_eq("clear_wdata", wdata_err, 0);
    bad = 0;
    for (int i = 0; i < Depth; i++) if (mem[i] != ((i < n) ? 16'd0 : init_vals[i])) bad++;
    check_eq("mem_after", bad, 0);
    check_eq("hold_stable", hold_err, 0);
    check_eq("stall_eq_busy", stall_err, 0);
    check_eq("occupancy", occ_err, 0);
    check_eq("busy_span", busy_cnt, done_cyc - start_cyc);
    check_eq("idle_after", busy_o, 0);
    if (n == 0) begin
      check_eq("n0_valid", valid_cnt, 0);
      check_eq("n0_done_lat", done_cyc - start_cyc, 1);
    end else begin
      check_eq("done_after_pop", done_cyc - last_pop_cyc, 1);
    end
    if (mode == 0 && n > 0) begin
      check_eq("lat_ren", first_ren, 1);
      check_eq("lat_wen", first_wen, 2);
      check_eq("lat_out", first_out, 3);
      check_eq("lat_done", done_cyc - start_cyc, n + 3);
    end
  endtask

  initial begin
    rst           = 1'b1;
    start_i       = 1'b0;
    num_entries_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctl", {sc_ren_o, sc_wen_o, out_valid_o, out_last_o, busy_o,
                         stall_pipeline_o, done_o}, 0);
    check_eq("rst_data", out_data_o, 0);
    check_eq("rst_addr", {sc_raddr_o, sc_waddr_o}, 0);
    check_eq("rst_wdata", sc_wdata_o, 0);
    rst = 1'b0;

    run_drain(4, 0, 1'b0, 1'b1);
    run_drain(4, 1, 1'b0, 1'b0);
    run_drain(0, 0, 1'b0, 1'b0);
    run_drain(256, 2, 1'b0, 1'b0);

    // Abort an 8-entry drain with reset in its fifth cycle.
    load_mem(1'b0);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    start_i       = 1'b1;
    num_entries_i = 9'd8;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_abort_busy", busy_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_ctl", {sc_ren_o, sc_wen_o, out_valid_o, out_last_o, busy_o,
                           stall_pipeline_o, done_o}, 0);
    check_eq("abort_data", out_data_o, 0);
    check_eq("abort_addr", {sc_raddr_o, sc_waddr_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_drain(2, 0, 1'b0, 1'b0);

    run_drain(6, 0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) run_drain(int'($urandom_range(1, 40)), 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
